// File: rtl/irq_controller_if.sv
// Data-memory slave port plus the I_Req/IACK handshake between the core
// and the interrupt controller.
//   Data_addr  core data address
//   Wdata      core store data
//   we         core byte write enables
//   rdata      register read data (combinational from Data_addr)
//   sel        Data_addr falls inside the controller's register window
//   I_Req      interrupt request to the core
//   IACK       interrupt acknowledge from the core
interface irq_controller_if;
  logic [31:0] Data_addr;
  logic [31:0] Wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        sel;
  logic        I_Req;
  logic        IACK;

  modport master (
    output Data_addr, Wdata, we, IACK,
    input  rdata, sel, I_Req
  );

  modport slave (
    input  Data_addr, Wdata, we, IACK,
    output rdata, sel, I_Req
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller for the RV32I core's I_Req/IACK handshake.
// Latches rising edges on external sources, masks them with ENABLE, raises
// I_Req, claims the lowest-index active source on IACK and holds it in
// service until software writes EOI.
//
// Ports:
//   clk         core clock
//   reset       asynchronous active-low reset
//   irq_src     asynchronous interrupt lines, rising edge = event
//   bus         data-memory slave port + I_Req/IACK (irq_controller_if.slave)
//   claim_id    source currently in service
//   in_service  high while a claim is being serviced
//
// Register window (offset from BASE_ADDR):
//   0x0 PENDING  RW1C
//   0x4 ENABLE   RW
//   0x8 CLAIM    RO, all-ones after a spurious claim
//   0xC EOI      WO, any full-word write ends service
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no request outstanding; waits for an enabled pending source
// S_REQ    | I_Req high, waiting (unbounded) for IACK from the core
// S_SERVICE| claim taken; waits for an EOI write, IACK ignored
module irq_controller #(
  parameter int          N_SRC     = 8,             // 1..31
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          SYNC_STG  = 2              // >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  irq_controller_if.slave  bus,
  output logic [4:0]       claim_id,
  output logic             in_service
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ireq;
  logic             r_in_service;
  logic [4:0]       r_claim_id;
  logic             r_spurious;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  logic [N_SRC-1:0] r_sync [SYNC_STG];
  logic [N_SRC-1:0] r_hist;

  logic [31:0]      w_off;
  logic             w_sel;
  logic             w_wr;
  logic             w_wr_pend;
  logic             w_wr_en;
  logic             w_wr_eoi;
  logic [N_SRC-1:0] w_wdata;
  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_act;
  logic [4:0]       w_winner;
  logic [N_SRC-1:0] w_win_mask;
  logic             w_claim;
  logic [N_SRC-1:0] w_clr_mask;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Address decode: the subtraction wraps for addresses below BASE_ADDR,
  // so a single unsigned compare covers both ends of the window.
  assign w_off     = bus.Data_addr - BASE_ADDR;
  assign w_sel     = (w_off <= 32'hC);
  assign w_wr      = w_sel && (bus.we == 4'b1111);
  assign w_wr_pend = w_wr && (w_off[3:2] == 2'd0);
  assign w_wr_en   = w_wr && (w_off[3:2] == 2'd1);
  assign w_wr_eoi  = w_wr && (w_off[3:2] == 2'd3);
  assign w_wdata   = bus.Wdata[N_SRC-1:0];
  assign w_unused  = ^bus.Wdata[31:N_SRC];

  // Input synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STG; s++) r_sync[s] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= irq_src;
      for (int s = 1; s < SYNC_STG; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= r_sync[SYNC_STG-1];
    end
  end

  assign w_edge = r_sync[SYNC_STG-1] & ~r_hist;
  assign w_act  = r_pending & r_enable;

  // Lowest set index of the active vector wins.
  always_comb begin
    w_winner   = '0;
    w_win_mask = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_winner   = 5'(i);
        w_win_mask = '0;
        w_win_mask[i] = 1'b1;
      end
    end
  end

  assign w_claim    = (r_state == S_REQ) && bus.IACK && (w_act != '0);
  assign w_clr_mask = (w_wr_pend ? w_wdata : '0) | (w_claim ? w_win_mask : '0);

  // A new edge wins over a same-cycle clear of the same bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_enable  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_edge;
      if (w_wr_en) r_enable <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ireq       <= 1'b0;
      r_in_service <= 1'b0;
      r_claim_id   <= '0;
      r_spurious   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_act != '0) begin
            r_state <= S_REQ;
            r_ireq  <= 1'b1;
          end
        end
        S_REQ: begin
          // The request is never withdrawn; if the mask emptied while we
          // waited, the claim is reported as spurious.
          if (bus.IACK) begin
            if (w_act != '0) begin
              r_claim_id <= w_winner;
              r_spurious <= 1'b0;
            end else begin
              r_claim_id <= '0;
              r_spurious <= 1'b1;
            end
            r_ireq       <= 1'b0;
            r_in_service <= 1'b1;
            r_state      <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          // IACK lingers for a cycle after I_Req falls; only EOI matters here.
          if (w_wr_eoi) begin
            r_in_service <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_ireq       <= 1'b0;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off[3:2])
        2'd0:    w_rdata = {{(32-N_SRC){1'b0}}, r_pending};
        2'd1:    w_rdata = {{(32-N_SRC){1'b0}}, r_enable};
        2'd2:    w_rdata = r_spurious ? 32'hFFFF_FFFF : {27'b0, r_claim_id};
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.rdata  = w_rdata;
  assign bus.sel    = w_sel;
  assign bus.I_Req  = r_ireq;
  assign claim_id   = r_claim_id;
  assign in_service = r_in_service;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
  localparam logic [31:0] BASE    = 32'hFFFF_0000;
  localparam logic [31:0] A_PEND  = BASE;
  localparam logic [31:0] A_EN    = BASE + 32'h4;
  localparam logic [31:0] A_CLAIM = BASE + 32'h8;
  localparam logic [31:0] A_EOI   = BASE + 32'hC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irq_src = 8'h00;
  logic [4:0] claim_id;
  logic       in_service;

  irq_controller_if bus();

  irq_controller #(.N_SRC(8), .BASE_ADDR(BASE), .SYNC_STG(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .bus        (bus),
    .claim_id   (claim_id),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.Data_addr = a;
    bus.Wdata     = d;
    bus.we        = be;
    @(negedge clk);
    bus.we        = 4'h0;
    bus.Data_addr = 32'h0;
    bus.Wdata     = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.Data_addr = a;
    bus.we        = 4'h0;
    #1;
    d = bus.rdata;
  endtask

  task automatic wait_ireq(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.I_Req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Core behaviour: IACK for the cycle that retires I_Req and one more.
  task automatic iack_pulse();
    bus.IACK = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.IACK = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    irq_src = 8'hFF;
    #12;
    n_checks++;
    if (bus.I_Req !== 1'b0) begin n_errors++; $display("FAIL reset_ireq got=%b exp=0", bus.I_Req); end
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reset_pending got=%h exp=0", d); end
    bus_read(A_EN, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reset_enable got=%h exp=0", d); end
    irq_src = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reset_pending_after got=%h exp=0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [31:0] e;
    @(negedge clk);
    bus_write(A_EN, 32'h4, 4'hF);
    irq_src[2] = 1'b1;
    exp_q.push_back(32'd2);
    repeat (2) @(negedge clk);
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL basic_pend_early got=%h exp=0", d); end
    @(negedge clk);
    irq_src[2] = 1'b0;
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL basic_pend_latency got=%h exp=4", d); end
    n_checks++;
    if (bus.I_Req !== 1'b0) begin n_errors++; $display("FAIL basic_ireq_early got=%b exp=0", bus.I_Req); end
    @(negedge clk);
    n_checks++;
    if (bus.I_Req !== 1'b1) begin n_errors++; $display("FAIL basic_ireq_rise got=%b exp=1", bus.I_Req); end
    iack_pulse();
    n_checks++;
    if (bus.I_Req !== 1'b0 || in_service !== 1'b1 || claim_id !== 5'd2) begin
      n_errors++;
      $display("FAIL basic_after_iack got ireq=%b insvc=%b id=%0d exp ireq=0 insvc=1 id=2", bus.I_Req, in_service, claim_id);
    end
    bus_read(A_CLAIM, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_checks++;
    if (d !== e) begin n_errors++; $display("FAIL basic_claim got=%h exp=%h", d, e); end
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL basic_pend_cleared got=%h exp=0", d); end
    @(negedge clk);
    bus_write(A_EOI, 32'h0, 4'hF);
    @(negedge clk);
    n_checks++;
    if (in_service !== 1'b0 || bus.I_Req !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_eoi got insvc=%b ireq=%b exp 0 0", in_service, bus.I_Req);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    logic [31:0] e;
    bit ok;
    bus_write(A_EN, 32'hFF, 4'hF);
    irq_src = 8'h22;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd5);
    repeat (2) @(negedge clk);
    irq_src = 8'h00;
    for (int k = 0; k < 2; k++) begin
      wait_ireq(10, ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL prio_ireq_timeout round=%0d got=0 exp=1", k); end
      iack_pulse();
      bus_read(A_CLAIM, d);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_checks++;
      if (d !== e) begin n_errors++; $display("FAIL prio_claim round=%0d got=%h exp=%h", k, d, e); end
      @(negedge clk);
      bus_write(A_EOI, 32'h0, 4'hF);
    end
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL prio_pend_empty got=%h exp=0", d); end
  endtask

  task automatic test_spurious();
    logic [31:0] d;
    logic [31:0] e;
    bit ok;
    bit quiet;
    bus_write(A_EN, 32'h0, 4'hF);
    irq_src[3] = 1'b1;
    repeat (2) @(negedge clk);
    irq_src[3] = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.I_Req !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin n_errors++; $display("FAIL mask_ireq_quiet got=1 exp=0"); end
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h8) begin n_errors++; $display("FAIL mask_pend got=%h exp=8", d); end
    @(negedge clk);
    bus_write(A_EN, 32'h8, 4'hF);
    wait_ireq(10, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL mask_ireq_timeout got=0 exp=1"); end
    bus_write(A_EN, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.I_Req !== 1'b1) begin n_errors++; $display("FAIL mask_no_retract got=%b exp=1", bus.I_Req); end
    exp_q.push_back(32'hFFFF_FFFF);
    iack_pulse();
    bus_read(A_CLAIM, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_checks++;
    if (d !== e) begin n_errors++; $display("FAIL spurious_claim got=%h exp=%h", d, e); end
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h8) begin n_errors++; $display("FAIL spurious_pend_kept got=%h exp=8", d); end
    @(negedge clk);
    bus_write(A_EOI, 32'h0, 4'hF);
    bus_write(A_PEND, 32'h8, 4'hF);
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL w1c_clear got=%h exp=0", d); end
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    logic [31:0] e;
    bit ok;
    @(negedge clk);
    irq_src[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(A_PEND, 32'h1, 4'hF);
    bus_read(A_PEND, d);
    n_checks++;
    if (d[0] !== 1'b1) begin n_errors++; $display("FAIL coll_set_wins got=%h exp bit0=1", d); end
    @(negedge clk);
    bus_write(A_PEND, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL coll_level_no_retrigger got=%h exp=0", d); end
    irq_src[0] = 1'b0;
    repeat (3) @(negedge clk);

    bus_write(A_EN, 32'h1, 4'hF);
    irq_src[0] = 1'b1;
    exp_q.push_back(32'd0);
    repeat (2) @(negedge clk);
    irq_src[0] = 1'b0;
    wait_ireq(10, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL coll_ireq_timeout got=0 exp=1"); end
    bus_write(A_EOI, 32'h0, 4'hF);
    @(negedge clk);
    n_checks++;
    if (bus.I_Req !== 1'b1 || in_service !== 1'b0) begin
      n_errors++;
      $display("FAIL coll_eoi_in_req got ireq=%b insvc=%b exp ireq=1 insvc=0", bus.I_Req, in_service);
    end
    iack_pulse();
    bus_read(A_CLAIM, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_checks++;
    if (d !== e || in_service !== 1'b1) begin
      n_errors++;
      $display("FAIL coll_claim0 got=%h insvc=%b exp=%h insvc=1", d, in_service, e);
    end
    @(negedge clk);
    bus_write(A_EOI, 32'h0, 4'hF);

    bus_write(A_EN, 32'hFF, 4'b0001);
    bus_read(A_EN, d);
    n_checks++;
    if (d !== 32'h1) begin n_errors++; $display("FAIL coll_subword got=%h exp=1", d); end
    @(negedge clk);
    bus_write(A_EN, 32'h0, 4'hF);
    bus_read(A_EN, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL coll_enable_write got=%h exp=0", d); end
  endtask

  task automatic test_stall_reset();
    logic [31:0] d;
    bit ok;
    bit held;
    @(negedge clk);
    bus_write(A_EN, 32'h2, 4'hF);
    irq_src[1] = 1'b1;
    repeat (2) @(negedge clk);
    irq_src[1] = 1'b0;
    wait_ireq(10, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL stall_ireq_timeout got=0 exp=1"); end
    held = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.I_Req !== 1'b1) held = 1'b0;
    end
    n_checks++;
    if (!held) begin n_errors++; $display("FAIL stall_ireq_held got=0 exp=1"); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.I_Req !== 1'b0 || in_service !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got ireq=%b insvc=%b exp 0 0", bus.I_Req, in_service);
    end
    @(negedge clk);
    reset = 1'b1;
    held = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.I_Req !== 1'b0) held = 1'b0;
    end
    n_checks++;
    if (!held) begin n_errors++; $display("FAIL post_reset_idle got ireq=1 exp=0"); end
    bus_read(A_PEND, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL post_reset_pend got=%h exp=0", d); end
    bus_read(A_EN, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL post_reset_en got=%h exp=0", d); end
  endtask

  initial begin
    bus.Data_addr = 32'h0;
    bus.Wdata     = 32'h0;
    bus.we        = 4'h0;
    bus.IACK      = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_spurious();
    test_collisions();
    test_stall_reset();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
